// File: rtl/md_unit_pkg.sv
// Shared md_op encodings and FSM state type for the multiply/divide unit.
// The E-stage decoder and the hazard unit import the same values.
package md_unit_pkg;

    typedef enum logic [3:0] {
        MD_NONE  = 4'd0,
        MD_MULT  = 4'd1,
        MD_MULTU = 4'd2,
        MD_DIV   = 4'd3,
        MD_DIVU  = 4'd4,
        MD_MFHI  = 4'd5,
        MD_MFLO  = 4'd6,
        MD_MTHI  = 4'd7,
        MD_MTLO  = 4'd8
    } md_op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } md_state_e;

    function automatic logic is_arith_op(input logic [3:0] op);
        return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
    endfunction

    function automatic logic is_mult_op(input logic [3:0] op);
        return (op == MD_MULT) || (op == MD_MULTU);
    endfunction

endpackage

// File: rtl/md_arith.sv
// Combinational datapath producing {HI,LO} for the latched mult/div operation.
// write_en is low for a divide by zero so HI/LO keep their old contents.
module md_arith
    import md_unit_pkg::*;
(
    input  logic [3:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [63:0] result,
    output logic        write_en
);

    logic [63:0] a_sext, b_sext, a_zext, b_zext;
    logic [31:0] a_mag, b_mag, b_safe, mag_safe, uq, ur;
    logic [31:0] sq, sr;

    assign a_sext = {{32{a[31]}}, a};
    assign b_sext = {{32{b[31]}}, b};
    assign a_zext = {32'd0, a};
    assign b_zext = {32'd0, b};

    // Signed divide works on magnitudes so 0x80000000 / -1 wraps to 0x80000000.
    assign a_mag    = a[31] ? (~a + 32'd1) : a;
    assign b_mag    = b[31] ? (~b + 32'd1) : b;
    assign b_safe   = (b == 32'd0) ? 32'd1 : b;
    assign mag_safe = (b_mag == 32'd0) ? 32'd1 : b_mag;
    assign uq       = a_mag / mag_safe;
    assign ur       = a_mag % mag_safe;
    assign sq       = (a[31] ^ b[31]) ? (~uq + 32'd1) : uq;
    assign sr       = a[31] ? (~ur + 32'd1) : ur;

    always_comb begin
        result   = 64'd0;
        write_en = 1'b1;
        case (op)
            MD_MULT:  result = a_sext * b_sext;
            MD_MULTU: result = a_zext * b_zext;
            MD_DIV:   result = {sr, sq};
            MD_DIVU:  result = {a % b_safe, a / b_safe};
            default:  result = 64'd0;
        endcase
        if (((op == MD_DIV) || (op == MD_DIVU)) && (b == 32'd0))
            write_en = 1'b0;
    end

endmodule

// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit holding HI/LO for the E stage.
// busy covers cycles T+1..T+N after a start; HI/LO update at the edge ending T+N.
module md_unit
    import md_unit_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  md_op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic [31:0] md_out
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW         = $clog2(MAX_CYCLES + 1);

    md_state_e   state_reg;
    logic [CW-1:0] cnt_reg;
    logic [3:0]  op_reg;
    logic [31:0] a_reg, b_reg, hi_reg, lo_reg;
    logic [63:0] arith_result;
    logic        arith_write_en;

    md_arith u_arith (
        .op       (op_reg),
        .a        (a_reg),
        .b        (b_reg),
        .result   (arith_result),
        .write_en (arith_write_en)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= '0;
            op_reg    <= 4'd0;
            a_reg     <= 32'd0;
            b_reg     <= 32'd0;
            hi_reg    <= 32'd0;
            lo_reg    <= 32'd0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (start && is_arith_op(md_op)) begin
                        state_reg <= ST_RUN;
                        op_reg    <= md_op;
                        a_reg     <= A;
                        b_reg     <= B;
                        cnt_reg   <= is_mult_op(md_op) ? CW'(MULT_CYCLES) : CW'(DIV_CYCLES);
                    end else if (!start) begin
                        if (md_op == MD_MTHI)
                            hi_reg <= A;
                        else if (md_op == MD_MTLO)
                            lo_reg <= A;
                    end
                end
                ST_RUN: begin
                    cnt_reg <= cnt_reg - CW'(1);
                    if (cnt_reg == CW'(1)) begin
                        state_reg <= ST_IDLE;
                        if (arith_write_en) begin
                            hi_reg <= arith_result[63:32];
                            lo_reg <= arith_result[31:0];
                        end
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign busy = (state_reg == ST_RUN);
    assign HI   = hi_reg;
    assign LO   = lo_reg;

    always_comb begin
        md_out = 32'd0;
        if (md_op == MD_MFHI)
            md_out = hi_reg;
        else if (md_op == MD_MFLO)
            md_out = lo_reg;
    end

endmodule
